// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO pair: shift-add multiply and
// restoring divide at one bit per cycle. Optional signed ops: define MULDIV_SIGNED_EN.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic [WIDTH-1:0]   r_opnd;      // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0] r_acc;       // {upper product, multiplier} or {remainder, quotient}
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

`ifdef MULDIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_sa;
    logic w_sb;

    assign w_sa    = op[0] & rs[WIDTH-1];
    assign w_sb    = op[0] & rt[WIDTH-1];
    assign w_mag_a = w_sa ? ('0 - rs) : rs;
    assign w_mag_b = w_sb ? ('0 - rt) : rt;
`else
    logic w_unused_op0;

    assign w_unused_op0 = op[0];
    assign w_mag_a      = rs;
    assign w_mag_b      = rt;
`endif

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Remainder stays below the divisor, so a WIDTH-bit modular subtract is exact when taken.
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge  = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opnd;
    assign w_div_acc = {(w_div_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_div_ge};

    always_comb begin
        w_res_hi = r_acc[2*WIDTH-1:WIDTH];
        w_res_lo = r_acc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (r_is_div) begin
            if (r_neg_q) w_res_lo = '0 - r_acc[WIDTH-1:0];
            if (r_neg_r) w_res_hi = '0 - r_acc[2*WIDTH-1:WIDTH];
        end else if (r_neg_q) begin
            {w_res_hi, w_res_lo} = '0 - r_acc;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != S_IDLE);
        stall = mf_req & (busy | start);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_is_div <= op[1];
                        r_cnt    <= CW'(WIDTH - 1);
                        r_opnd   <= op[1] ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
`ifdef MULDIV_SIGNED_EN
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
`endif
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_acc <= r_is_div ? w_div_acc : w_mul_acc;
                end
                S_FIX: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle-level reference model plus directed cases.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs, rt, wdata;
    logic         hi_we, lo_we, mf_req;
    logic         busy, done, stall;
    logic [W-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int e0       = 0;
    bit chk_en   = 1'b0;

    muldiv_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .rs(rs), .rt(rt),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .mf_req(mf_req),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one op as {hi, lo}.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic            sgn;
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [W-1:0]    q, r;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (!o[1]) return sgn ? 64'(sa * sb) : 64'(ua * ub);
        if (b == 0) begin
            q = (sgn && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Reference model: an accepted op completes WIDTH+1 edges later.
    logic [W-1:0] m_hi, m_lo;
    logic [63:0]  m_pend;
    int           m_cnt;
    logic         m_done;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_hi <= '0; m_lo <= '0; m_cnt <= 0; m_done <= 1'b0; m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
                if (start) begin
                    m_pend <= ref_res(op, rs, rt);
                    m_cnt  <= W + 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy",  64'(busy),  64'(m_cnt != 0));
            chk("done",  64'(done),  64'(m_done));
            chk("stall", 64'(stall), 64'(mf_req & ((m_cnt != 0) | start)));
            chk("hi",    64'(hi),    64'(m_hi));
            chk("lo",    64'(lo),    64'(m_lo));
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0: return '0;
            1: return 32'd1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge CLK); #2;
        start = 1'b1; op = o; rs = a; rt = b;
        e0 = cyc + 1;
        @(posedge CLK); #2;
        start = 1'b0; rs = $urandom; rt = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            if (done) begin
                lat = cyc - e0;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done within 100 cycles");
        end
    endtask

    int lat;
    int ndone;

    initial begin
        RST = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; mf_req = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk_en = 1'b1;
        @(posedge CLK); #2 RST = 1'b1;

        launch(2'b00, 32'hFFFF_FFFF, 32'd2);
        wait_done(lat);
        chk("t1_latency", 64'(lat), 64'd33);
        chk("t1_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        launch(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat);
`ifdef MULDIV_SIGNED_EN
        chk("t2_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
        chk("t2_hilo", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
`endif

        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
`ifdef MULDIV_SIGNED_EN
        chk("t3_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
        chk("t3_div", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
`endif
        launch(2'b10, 32'd7, 32'd0);
        wait_done(lat);
        chk("t3_divu0", {hi, lo}, 64'h0000_0007_FFFF_FFFF);

        @(posedge CLK); #2;
        mf_req = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
        @(posedge CLK); #2 hi_we = 1'b0;
        @(negedge CLK);
        chk("t4_mthi", 64'(hi), 64'h1234);
        launch(2'b00, 32'd3, 32'd4);
        chk("t4_stall_busy", 64'(stall), 64'd1);
        wait_done(lat);
        chk("t4_hilo", {hi, lo}, 64'd12);
        chk("t4_stall_done", 64'(stall), 64'd0);
        @(posedge CLK); #2 mf_req = 1'b0;

        launch(2'b00, 32'd6, 32'd7);
        ndone = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge CLK); #2;
            start = ((i < 20) && (i % 3 == 0)) || (i == 30);
            op = 2'b10; rs = $urandom; rt = $urandom;
            hi_we = (i < 20) && (i % 4 == 1);
            lo_we = (i == 30);
            wdata = 32'hDEAD_BEEF;
            @(negedge CLK);
            if (done) ndone++;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("t5_single_done", 64'(ndone), 64'd1);
        chk("t5_hilo", {hi, lo}, 64'd42);
        chk("t5_idle", 64'(busy), 64'd0);

        launch(2'b00, 32'd9, 32'd9);
        repeat (9) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_hilo", {hi, lo}, 64'd0);
        @(posedge CLK); #2 RST = 1'b1;
        launch(2'b10, 32'd100, 32'd7);
        wait_done(lat);
        chk("t6_latency", 64'(lat), 64'd33);
        chk("t6_hilo_after", {hi, lo}, 64'h0000_0002_0000_000E);

        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK); #2;
            start  = ($urandom % 6 == 0);
            op     = 2'($urandom);
            rs     = pick();
            rt     = pick();
            hi_we  = ($urandom % 8 == 0);
            lo_we  = ($urandom % 8 == 0);
            wdata  = $urandom;
            mf_req = 1'($urandom);
            RST    = ($urandom % 600 != 0);
        end
        @(posedge CLK); #2;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; mf_req = 1'b0; RST = 1'b1;
        repeat (40) @(posedge CLK);
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
